// File: rtl/timestep_sequencer.sv
// Debounced Execute-button step sequencer: produces STEP strobes, the 2-bit TIME and the Clr level.
// Optional TIMESTEP_SEQ_AUTOSTEP_EN adds RUN/AUTO_PERIOD free-running auto-stepping.
module timestep_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16
`ifdef TIMESTEP_SEQ_AUTOSTEP_EN
    ,
    parameter int AUTO_PERIOD = 8
`endif
) (
    input  logic       Clock,
    input  logic       Resetb,
    input  logic       EXECb,
    input  logic       LAST,
`ifdef TIMESTEP_SEQ_AUTOSTEP_EN
    input  logic       RUN,
`endif
    output logic [1:0] TIME,
    output logic       Clr,
    output logic       STEP
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REL,
        PCHK,
        PRS,
        RCHK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sync1;
    logic             sync;

`ifdef TIMESTEP_SEQ_AUTOSTEP_EN
    localparam int AW = $clog2(AUTO_PERIOD);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
    logic [AW-1:0] acnt;
`endif

    always_ff @(posedge Clock) begin
        if (!Resetb) begin
            sync1 <= 1'b1;
            sync  <= 1'b1;
            // Reset lands in PRS so a button held through reset must be released first.
            state <= PRS;
            cnt   <= '0;
            STEP  <= 1'b0;
            TIME  <= '0;
            Clr   <= 1'b0;
`ifdef TIMESTEP_SEQ_AUTOSTEP_EN
            acnt  <= '0;
`endif
        end else begin
            sync1 <= EXECb;
            sync  <= sync1;
            STEP  <= 1'b0;

            case (state)
                REL: begin
                    if (!sync) begin
                        state <= PCHK;
                        cnt   <= '0;
                    end
                end
                PCHK: begin
                    if (sync) begin
                        state <= REL;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRS;
`ifdef TIMESTEP_SEQ_AUTOSTEP_EN
                        STEP  <= !RUN;
`else
                        STEP  <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRS: begin
                    if (sync) begin
                        state <= RCHK;
                        cnt   <= '0;
                    end
                end
                RCHK: begin
                    if (!sync) begin
                        state <= PRS;
                    end else if (cnt == CNT_LAST) begin
                        state <= REL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase

`ifdef TIMESTEP_SEQ_AUTOSTEP_EN
            if (RUN) begin
                if (acnt == AUTO_LAST) begin
                    acnt <= '0;
                    STEP <= 1'b1;
                end else begin
                    acnt <= acnt + AW'(1);
                end
            end else begin
                acnt <= '0;
            end
`endif

            if (STEP) begin
                if (LAST || TIME == 2'd3) begin
                    TIME <= '0;
                    Clr  <= 1'b1;
                end else begin
                    TIME <= TIME + 2'd1;
                    Clr  <= 1'b0;
                end
            end
        end
    end

endmodule
